// File: rtl/vram_arbiter_pkg.sv
// Shared encodings and defaults for the video RAM arbiter.
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CPU  = 2'd2
  } gnt_t;

  typedef enum logic [1:0] {
    TAG_NONE   = 2'd0,
    TAG_DISP   = 2'd1,
    TAG_CPU_RD = 2'd2
  } tag_t;

  localparam int unsigned STARVE_MAX_DEF = 3;
  localparam int unsigned STARVE_W       = 4;

endpackage

// File: rtl/vram_arb_starve.sv
// Starvation counter and priority decision: the display path wins unless the
// CPU has already lost STARVE_MAX consecutive arbitrations.
module vram_arb_starve
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                disp_req,
  input  logic                cpu_req,
  output logic                cpu_wins,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  assign cpu_wins = cpu_req && (!disp_req || (starve_cnt == CNT_MAX));

  // Count consecutive lost arbitrations; any CPU grant or idle CPU clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (cpu_req && disp_req && !cpu_wins) begin
      starve_cnt <= (starve_cnt == CNT_MAX) ? starve_cnt : starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display fetch has priority, the CPU is
// guaranteed a slot within STARVE_MAX+1 cycles. Read data returns one clock
// after the grant, tagged by requester.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 15,
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_adr,
  output logic          disp_ack,
  output logic [DW-1:0] disp_rdt,
  output logic          disp_vld,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdt,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdt,
  output logic          cpu_vld,
  output logic          cpu_wait,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdt,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdt
);

  logic                cpu_wins;
  logic [STARVE_W-1:0] starve_cnt;
  gnt_t                gnt;
  tag_t                tag_q;
  logic [AW-1:0]       adr_q;
  logic [DW-1:0]       wdt_q;
  logic [DW-1:0]       disp_rdt_q;
  logic [DW-1:0]       cpu_rdt_q;

  vram_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .disp_req  (disp_req),
    .cpu_req   (cpu_req),
    .cpu_wins  (cpu_wins),
    .starve_cnt(starve_cnt)
  );

  // Counter must never pass its saturation point.
  always_comb begin : starve_bound
    assert (starve_cnt <= STARVE_W'(STARVE_MAX));
  end

  // Grant decision; nothing is granted while reset is asserted.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (cpu_wins)      gnt = GNT_CPU;
      else if (disp_req) gnt = GNT_DISP;
    end
  end

  assign disp_ack = (gnt == GNT_DISP);
  assign cpu_ack  = (gnt == GNT_CPU);
  assign cpu_wait = cpu_req && !cpu_ack;

  // Drive the RAM port from the winner; address/data hold when idle.
  always_comb begin
    mem_adr = adr_q;
    mem_wdt = wdt_q;
    mem_we  = 1'b0;
    case (gnt)
      GNT_DISP: mem_adr = disp_adr;
      GNT_CPU: begin
        mem_adr = cpu_adr;
        mem_wdt = cpu_wdt;
        mem_we  = cpu_we;
      end
      default: ;
    endcase
  end

  // Registered RAM data is already valid in the return cycle, so it is passed
  // straight through there and captured to hold until the next return.
  assign disp_vld = (tag_q == TAG_DISP);
  assign cpu_vld  = (tag_q == TAG_CPU_RD);
  assign disp_rdt = disp_vld ? mem_rdt : disp_rdt_q;
  assign cpu_rdt  = cpu_vld  ? mem_rdt : cpu_rdt_q;

  // Return tag, held RAM port values and held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= TAG_NONE;
      adr_q      <= '0;
      wdt_q      <= '0;
      disp_rdt_q <= '0;
      cpu_rdt_q  <= '0;
    end else begin
      adr_q      <= mem_adr;
      wdt_q      <= mem_wdt;
      disp_rdt_q <= disp_rdt;
      cpu_rdt_q  <= cpu_rdt;
      case (gnt)
        GNT_DISP: tag_q <= TAG_DISP;
        GNT_CPU:  tag_q <= cpu_we ? TAG_NONE : TAG_CPU_RD;
        default:  tag_q <= TAG_NONE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised bench for vram_arbiter against a requester-level reference model.
module tb_vram_arbiter;

  localparam int unsigned AW   = 15;
  localparam int unsigned DW   = 8;
  localparam int unsigned SMAX = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_adr = '0;
  logic          disp_ack;
  logic [DW-1:0] disp_rdt;
  logic          disp_vld;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_adr = '0;
  logic [DW-1:0] cpu_wdt = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdt;
  logic          cpu_vld;
  logic          cpu_wait;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wdt;
  logic          mem_we;
  logic [DW-1:0] mem_rdt;

  vram_arbiter #(
    .AW(AW),
    .DW(DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .disp_req(disp_req),
    .disp_adr(disp_adr),
    .disp_ack(disp_ack),
    .disp_rdt(disp_rdt),
    .disp_vld(disp_vld),
    .cpu_req (cpu_req),
    .cpu_we  (cpu_we),
    .cpu_adr (cpu_adr),
    .cpu_wdt (cpu_wdt),
    .cpu_ack (cpu_ack),
    .cpu_rdt (cpu_rdt),
    .cpu_vld (cpu_vld),
    .cpu_wait(cpu_wait),
    .mem_adr (mem_adr),
    .mem_wdt (mem_wdt),
    .mem_we  (mem_we),
    .mem_rdt (mem_rdt)
  );

  always #5 clk = ~clk;

  // Registered single-port RAM, with a side port for preloading.
  logic [DW-1:0] ram [0:32767];
  logic          load_en  = 1'b0;
  logic [AW-1:0] load_adr = '0;
  logic [DW-1:0] load_dat = '0;

  always @(posedge clk) begin
    if (load_en)     ram[load_adr] <= load_dat;
    else if (mem_we) ram[mem_adr]  <= mem_wdt;
    mem_rdt <= ram[mem_adr];
  end

  // Reference model state
  logic [DW-1:0] ref_mem [0:32767];
  int unsigned   losses = 0;
  bit            pend_d = 0, pend_c = 0;
  logic [DW-1:0] pend_d_data = '0, pend_c_data = '0;
  logic [AW-1:0] hold_adr = '0;
  logic [DW-1:0] hold_wdt = '0;
  logic [DW-1:0] exp_disp_rdt = '0, exp_cpu_rdt = '0;
  int            last_g = 0;
  int unsigned   wait_run = 0, max_run = 0;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_en  = 1'b1;
    load_adr = a;
    load_dat = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // One clock: drive inputs, check all outputs against the model, advance.
  task automatic step(input logic r, input logic dr, input logic [AW-1:0] da,
                      input logic cr, input logic cw, input logic [AW-1:0] ca,
                      input logic [DW-1:0] cd);
    int g;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wdt;
    rst = r; disp_req = dr; disp_adr = da;
    cpu_req = cr; cpu_we = cw; cpu_adr = ca; cpu_wdt = cd;
    #4;
    if (r) begin
      losses = 0; pend_d = 0; pend_c = 0;
      exp_disp_rdt = '0; exp_cpu_rdt = '0;
      hold_adr = '0; hold_wdt = '0;
    end
    if (pend_d) exp_disp_rdt = pend_d_data;
    if (pend_c) exp_cpu_rdt  = pend_c_data;
    check("disp_vld", disp_vld, pend_d);
    check("cpu_vld",  cpu_vld,  pend_c);
    check("disp_rdt", disp_rdt, exp_disp_rdt);
    check("cpu_rdt",  cpu_rdt,  exp_cpu_rdt);
    check("starve_cnt", dut.u_starve.starve_cnt, losses);

    if (r)                                  g = 0;
    else if (cr && (!dr || losses == SMAX)) g = 2;
    else if (dr)                            g = 1;
    else                                    g = 0;
    e_adr = (g == 1) ? da : (g == 2) ? ca : hold_adr;
    e_wdt = (g == 2) ? cd : hold_wdt;
    check("disp_ack", disp_ack, g == 1);
    check("cpu_ack",  cpu_ack,  g == 2);
    check("cpu_wait", cpu_wait, cr && g != 2);
    check("mem_we",   mem_we,   g == 2 && cw);
    check("mem_adr",  mem_adr,  e_adr);
    check("mem_wdt",  mem_wdt,  e_wdt);

    if (cpu_wait) wait_run++; else wait_run = 0;
    if (wait_run > max_run) max_run = wait_run;

    hold_adr = e_adr;
    hold_wdt = e_wdt;
    pend_d = (g == 1);
    pend_d_data = ref_mem[da];
    pend_c = (g == 2) && !cw;
    pend_c_data = ref_mem[ca];
    if (g == 2 && cw) ref_mem[ca] = cd;
    if (cr && g == 1) losses = (losses == SMAX) ? losses : losses + 1;
    else              losses = 0;
    last_g = g;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    int cpu_slot;
    bit got;
    @(posedge clk); #1;

    // Preload RAM while reset is held.
    for (int unsigned i = 0; i < 64; i++) load(AW'(i), DW'($urandom));
    load(15'h0400, 8'h5A);
    load(15'h1234, DW'($urandom));

    // Reset state, then idle after release.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 20; i++) idle();

    // CPU read of a known location.
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 15'h0400, '0);
    idle();
    check("cpu_rdt_5a", cpu_rdt, 8'h5A);

    // CPU write followed by a display read of the same address.
    step(1'b0, 1'b0, '0, 1'b1, 1'b1, 15'h1234, 8'hC3);
    step(1'b0, 1'b1, 15'h1234, 1'b0, 1'b0, '0, '0);
    idle();
    check("disp_rdt_c3", disp_rdt, 8'hC3);

    // Display held busy; CPU read raised at cycle 5 must win at cycle 8.
    got = 0;
    cpu_slot = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, AW'(i), (i >= 5) && !got, 1'b0, 15'h0010, '0);
      if (last_g == 2 && !got) begin
        got = 1;
        cpu_slot = i;
      end
    end
    check("starve_slot", cpu_slot, 8);
    idle();

    // Both rise with an empty counter; then CPU drops.
    step(1'b0, 1'b1, 15'h0003, 1'b1, 1'b0, 15'h0004, '0);
    check("starve_one", dut.u_starve.starve_cnt, 1);
    step(1'b0, 1'b1, 15'h0005, 1'b0, 1'b0, '0, '0);
    check("starve_zero", dut.u_starve.starve_cnt, 0);
    idle();

    // Reset in the middle of a CPU read: the return is dropped.
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 15'h0007, '0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    idle();
    idle();

    // Random traffic on both ports.
    for (int i = 0; i < 1000; i++) begin
      step(1'b0,
           $urandom_range(0, 99) < 75, AW'($urandom_range(0, 63)),
           $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 63)), DW'($urandom));
    end
    idle();
    check("max_cpu_wait_bound", max_run <= SMAX + 1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
